// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM stage of the 64-bit RISC-V pipeline: data-memory handshake, stall, branch resolve, MEM/WB register
//
// Optional build macro: MEM_ALIGN_CHECK_EN
//   When defined, a misaligned access (EXM_ALUResult[2:0] != 0) is not issued.
//   The op retires as a bubble, and mem_misalign pulses high for one cycle.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   EXM_*                      EX/MEM pipeline register outputs (control, ALU result, store data, rd, branch target)
//   dmem_req/we/addr/wdata     registered data-memory request, held until ack or timeout
//   dmem_rdata, dmem_ack       read data and one-cycle completion strobe
//   mem_stall                  combinational hold for the upstream pipeline registers
//   PCSrc, branch_target       combinational branch resolution
//   MW_*                       MEM/WB pipeline register outputs
//   mem_err                    sticky access-timeout flag
//   mem_misalign               one-cycle misaligned-access pulse (MEM_ALIGN_CHECK_EN only)

module mem_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        EXM_RegWrite,
    input  logic        EXM_MemRead,
    input  logic        EXM_MemToReg,
    input  logic        EXM_MemWrite,
    input  logic        EXM_Branch,
    input  logic        EXM_Zero,
    input  logic [63:0] EXM_Adder_out,
    input  logic [63:0] EXM_ALUResult,
    input  logic [63:0] EXM_ReadData2,
    input  logic [4:0]  EXM_rd,
    input  logic [63:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic        mem_stall,
    output logic        PCSrc,
    output logic [63:0] branch_target,
    output logic        MW_RegWrite,
    output logic        MW_MemToReg,
    output logic [63:0] MW_ReadData,
    output logic [63:0] MW_ALUResult,
    output logic [4:0]  MW_rd,
    output logic        mem_err
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic        mem_misalign
`endif
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Last counter value before an access is abandoned.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        dmem_req_q, dmem_req_d;
    logic        dmem_we_q, dmem_we_d;
    logic [63:0] dmem_addr_q, dmem_addr_d;
    logic [63:0] dmem_wdata_q, dmem_wdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        mem_err_q, mem_err_d;
    // Writeback fields of the in-flight memory op, retired on ack.
    logic        hold_regwrite_q, hold_regwrite_d;
    logic        hold_memtoreg_q, hold_memtoreg_d;
    logic [4:0]  hold_rd_q, hold_rd_d;
    logic [63:0] hold_alu_q, hold_alu_d;
    logic        mw_regwrite_q, mw_regwrite_d;
    logic        mw_memtoreg_q, mw_memtoreg_d;
    logic [63:0] mw_readdata_q, mw_readdata_d;
    logic [63:0] mw_aluresult_q, mw_aluresult_d;
    logic [4:0]  mw_rd_q, mw_rd_d;

    logic mem_op;
    logic misaligned;
    logic stall;

`ifdef MEM_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;
    assign misaligned = (EXM_ALUResult[2:0] != 3'b000);
`else
    assign misaligned = 1'b0;
`endif

    assign mem_op = EXM_MemRead | EXM_MemWrite;

    always_comb begin
        state_d         = state_q;
        dmem_req_d      = dmem_req_q;
        dmem_we_d       = dmem_we_q;
        dmem_addr_d     = dmem_addr_q;
        dmem_wdata_d    = dmem_wdata_q;
        cnt_d           = cnt_q;
        mem_err_d       = mem_err_q;
        hold_regwrite_d = hold_regwrite_q;
        hold_memtoreg_d = hold_memtoreg_q;
        hold_rd_d       = hold_rd_q;
        hold_alu_d      = hold_alu_q;
        mw_regwrite_d   = mw_regwrite_q;
        mw_memtoreg_d   = mw_memtoreg_q;
        mw_readdata_d   = mw_readdata_q;
        mw_aluresult_d  = mw_aluresult_q;
        mw_rd_d         = mw_rd_q;
        stall           = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        misalign_d      = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (mem_op && misaligned) begin
                    mw_regwrite_d = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
                    misalign_d    = 1'b1;
`endif
                end else if (mem_op) begin
                    stall           = 1'b1;
                    dmem_req_d      = 1'b1;
                    // A malformed op with both flags set is treated as a load.
                    dmem_we_d       = EXM_MemWrite & ~EXM_MemRead;
                    dmem_addr_d     = EXM_ALUResult;
                    dmem_wdata_d    = EXM_ReadData2;
                    cnt_d           = 8'd0;
                    hold_regwrite_d = EXM_RegWrite;
                    hold_memtoreg_d = EXM_MemToReg;
                    hold_rd_d       = EXM_rd;
                    hold_alu_d      = EXM_ALUResult;
                    mw_regwrite_d   = 1'b0;
                    state_d         = ACCESS;
                end else begin
                    mw_regwrite_d  = EXM_RegWrite;
                    mw_memtoreg_d  = EXM_MemToReg;
                    mw_readdata_d  = 64'd0;
                    mw_aluresult_d = EXM_ALUResult;
                    mw_rd_d        = EXM_rd;
                end
            end
            ACCESS: begin
                if (dmem_ack) begin
                    // Stall released in the ack cycle so upstream advances on this same edge.
                    dmem_req_d     = 1'b0;
                    mw_regwrite_d  = hold_regwrite_q;
                    mw_memtoreg_d  = hold_memtoreg_q;
                    mw_readdata_d  = dmem_rdata;
                    mw_aluresult_d = hold_alu_q;
                    mw_rd_d        = hold_rd_q;
                    state_d        = IDLE;
                end else begin
                    stall         = 1'b1;
                    mw_regwrite_d = 1'b0;
                    if (cnt_q == CNT_LAST) begin
                        dmem_req_d = 1'b0;
                        mem_err_d  = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            dmem_req_q      <= 1'b0;
            dmem_we_q       <= 1'b0;
            dmem_addr_q     <= 64'd0;
            dmem_wdata_q    <= 64'd0;
            cnt_q           <= 8'd0;
            mem_err_q       <= 1'b0;
            hold_regwrite_q <= 1'b0;
            hold_memtoreg_q <= 1'b0;
            hold_rd_q       <= 5'd0;
            hold_alu_q      <= 64'd0;
            mw_regwrite_q   <= 1'b0;
            mw_memtoreg_q   <= 1'b0;
            mw_readdata_q   <= 64'd0;
            mw_aluresult_q  <= 64'd0;
            mw_rd_q         <= 5'd0;
`ifdef MEM_ALIGN_CHECK_EN
            misalign_q      <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            dmem_req_q      <= dmem_req_d;
            dmem_we_q       <= dmem_we_d;
            dmem_addr_q     <= dmem_addr_d;
            dmem_wdata_q    <= dmem_wdata_d;
            cnt_q           <= cnt_d;
            mem_err_q       <= mem_err_d;
            hold_regwrite_q <= hold_regwrite_d;
            hold_memtoreg_q <= hold_memtoreg_d;
            hold_rd_q       <= hold_rd_d;
            hold_alu_q      <= hold_alu_d;
            mw_regwrite_q   <= mw_regwrite_d;
            mw_memtoreg_q   <= mw_memtoreg_d;
            mw_readdata_q   <= mw_readdata_d;
            mw_aluresult_q  <= mw_aluresult_d;
            mw_rd_q         <= mw_rd_d;
`ifdef MEM_ALIGN_CHECK_EN
            misalign_q      <= misalign_d;
`endif
        end
    end

    assign dmem_req      = dmem_req_q;
    assign dmem_we       = dmem_we_q;
    assign dmem_addr     = dmem_addr_q;
    assign dmem_wdata    = dmem_wdata_q;
    assign mem_stall     = stall;
    assign PCSrc         = EXM_Branch & EXM_Zero;
    assign branch_target = EXM_Adder_out;
    assign MW_RegWrite   = mw_regwrite_q;
    assign MW_MemToReg   = mw_memtoreg_q;
    assign MW_ReadData   = mw_readdata_q;
    assign MW_ALUResult  = mw_aluresult_q;
    assign MW_rd         = mw_rd_q;
    assign mem_err       = mem_err_q;
`ifdef MEM_ALIGN_CHECK_EN
    assign mem_misalign  = misalign_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        EXM_RegWrite, EXM_MemRead, EXM_MemToReg, EXM_MemWrite, EXM_Branch, EXM_Zero;
    logic [63:0] EXM_Adder_out, EXM_ALUResult, EXM_ReadData2;
    logic [4:0]  EXM_rd;
    logic [63:0] dmem_rdata;
    logic        dmem_ack;
    logic        dmem_req, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata;
    logic        mem_stall, PCSrc;
    logic [63:0] branch_target;
    logic        MW_RegWrite, MW_MemToReg;
    logic [63:0] MW_ReadData, MW_ALUResult;
    logic [4:0]  MW_rd;
    logic        mem_err;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .EXM_RegWrite(EXM_RegWrite), .EXM_MemRead(EXM_MemRead), .EXM_MemToReg(EXM_MemToReg),
        .EXM_MemWrite(EXM_MemWrite), .EXM_Branch(EXM_Branch), .EXM_Zero(EXM_Zero),
        .EXM_Adder_out(EXM_Adder_out), .EXM_ALUResult(EXM_ALUResult), .EXM_ReadData2(EXM_ReadData2),
        .EXM_rd(EXM_rd), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .mem_stall(mem_stall), .PCSrc(PCSrc), .branch_target(branch_target),
        .MW_RegWrite(MW_RegWrite), .MW_MemToReg(MW_MemToReg), .MW_ReadData(MW_ReadData),
        .MW_ALUResult(MW_ALUResult), .MW_rd(MW_rd), .mem_err(mem_err)
    );

    typedef struct {
        logic        rw, mtr, br, zr;
        logic [63:0] adder, alu;
        logic [4:0]  rd;
        logic        exp_pcsrc;
        logic [63:0] exp_target;
        logic        exp_mw_rw, exp_mw_mtr;
        logic [63:0] exp_mw_alu;
        logic [4:0]  exp_mw_rd;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exm(input logic rw, input logic mr, input logic mtr, input logic mw,
                           input logic br, input logic zr, input logic [63:0] adder,
                           input logic [63:0] alu, input logic [63:0] rd2, input logic [4:0] rd);
        EXM_RegWrite  = rw;
        EXM_MemRead   = mr;
        EXM_MemToReg  = mtr;
        EXM_MemWrite  = mw;
        EXM_Branch    = br;
        EXM_Zero      = zr;
        EXM_Adder_out = adder;
        EXM_ALUResult = alu;
        EXM_ReadData2 = rd2;
        EXM_rd        = rd;
    endtask

    task automatic nop();
        set_exm(0, 0, 0, 0, 0, 0, 64'd0, 64'd0, 64'd0, 5'd0);
    endtask

    initial begin
        int stall_cnt;
        int n;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 64'h2A, 5'd5,
                    1'b0, 64'h0, 1'b1, 1'b0, 64'h2A, 5'd5};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 64'h400, 64'h0, 5'd0,
                    1'b1, 64'h400, 1'b0, 1'b0, 64'h0, 5'd0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 64'h400, 64'h8, 5'd0,
                    1'b0, 64'h400, 1'b0, 1'b0, 64'h8, 5'd0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 64'h123, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31,
                    1'b0, 64'h123, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31};

        reset = 1'b1;
        dmem_ack = 1'b0;
        dmem_rdata = 64'd0;
        nop();
        step();
        step();
        reset = 1'b0;
        chk("reset_req", dmem_req, 0);
        chk("reset_addr", dmem_addr, 0);
        chk("reset_mw_rw", MW_RegWrite, 0);
        chk("reset_err", mem_err, 0);
        chk("reset_stall", mem_stall, 0);

        // Non-memory ops and branch resolution
        for (int i = 0; i < 4; i++) begin
            set_exm(vecs[i].rw, 0, vecs[i].mtr, 0, vecs[i].br, vecs[i].zr,
                    vecs[i].adder, vecs[i].alu, 64'd0, vecs[i].rd);
            #1;
            chk($sformatf("v%0d_pcsrc", i), PCSrc, vecs[i].exp_pcsrc);
            chk($sformatf("v%0d_target", i), branch_target, vecs[i].exp_target);
            chk($sformatf("v%0d_stall", i), mem_stall, 0);
            step();
            chk($sformatf("v%0d_mw_rw", i), MW_RegWrite, vecs[i].exp_mw_rw);
            chk($sformatf("v%0d_mw_mtr", i), MW_MemToReg, vecs[i].exp_mw_mtr);
            chk($sformatf("v%0d_mw_alu", i), MW_ALUResult, vecs[i].exp_mw_alu);
            chk($sformatf("v%0d_mw_rd", i), MW_rd, vecs[i].exp_mw_rd);
            chk($sformatf("v%0d_mw_rdata", i), MW_ReadData, 0);
        end

        // Load, ack on the 4th ACCESS cycle (the timeout boundary)
        set_exm(1, 1, 1, 0, 0, 0, 64'd0, 64'h100, 64'd0, 5'd7);
        dmem_rdata = 64'hDEADBEEF;
        #1;
        stall_cnt = 0;
        if (mem_stall) stall_cnt++;
        step();
        chk("ld_req", dmem_req, 1);
        chk("ld_addr", dmem_addr, 64'h100);
        chk("ld_we", dmem_we, 0);
        chk("ld_bubble", MW_RegWrite, 0);
        for (int i = 0; i < 3; i++) begin
            if (mem_stall) stall_cnt++;
            step();
        end
        chk("ld_req_held", dmem_req, 1);
        dmem_ack = 1'b1;
        #1;
        chk("ld_ack_stall", mem_stall, 0);
        chk("ld_stall_cycles", stall_cnt, 4);
        step();
        dmem_ack = 1'b0;
        nop();
        chk("ld_req_drop", dmem_req, 0);
        chk("ld_mw_rdata", MW_ReadData, 64'hDEADBEEF);
        chk("ld_mw_rw", MW_RegWrite, 1);
        chk("ld_mw_rd", MW_rd, 7);
        chk("ld_mw_alu", MW_ALUResult, 64'h100);
        chk("ld_mw_mtr", MW_MemToReg, 1);
        step();
        chk("nop_rdata_clr", MW_ReadData, 0);

        // Store, ack after 1 cycle
        set_exm(0, 0, 0, 1, 0, 0, 64'd0, 64'h200, 64'h55, 5'd3);
        #1;
        chk("st_stall_idle", mem_stall, 1);
        step();
        chk("st_we", dmem_we, 1);
        chk("st_addr", dmem_addr, 64'h200);
        chk("st_wdata", dmem_wdata, 64'h55);
        chk("st_stall_acc", mem_stall, 1);
        step();
        dmem_ack = 1'b1;
        #1;
        chk("st_ack_stall", mem_stall, 0);
        step();
        dmem_ack = 1'b0;
        nop();
        chk("st_req_drop", dmem_req, 0);
        chk("st_mw_rw", MW_RegWrite, 0);

        // Both MemRead and MemWrite: treated as a load
        set_exm(0, 1, 0, 1, 0, 0, 64'd0, 64'h300, 64'h77, 5'd0);
        step();
        chk("both_we", dmem_we, 0);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        nop();

        // Timeout with TIMEOUT_CYCLES=4
        set_exm(1, 1, 1, 0, 0, 0, 64'd0, 64'h180, 64'd0, 5'd9);
        step();
        n = 0;
        while (dmem_req && n < 10) begin
            n++;
            step();
        end
        nop();
        #1;
        chk("to_access_cycles", n, 4);
        chk("to_err", mem_err, 1);
        chk("to_mw_rw", MW_RegWrite, 0);
        chk("to_idle_stall", mem_stall, 0);
        dmem_ack = 1'b1;
        dmem_rdata = 64'h1234;
        step();
        dmem_ack = 1'b0;
        chk("to_err_sticky", mem_err, 1);
        chk("idle_ack_ignored_req", dmem_req, 0);
        chk("idle_ack_ignored_rdata", MW_ReadData, 0);

        // Reset two cycles into a load
        set_exm(1, 1, 1, 0, 0, 0, 64'd0, 64'h1C0, 64'd0, 5'd4);
        step();
        step();
        reset = 1'b1;
        nop();
        step();
        reset = 1'b0;
        chk("rst_req", dmem_req, 0);
        chk("rst_mw_rw", MW_RegWrite, 0);
        chk("rst_mw_alu", MW_ALUResult, 0);
        chk("rst_mw_rd", MW_rd, 0);
        chk("rst_stall", mem_stall, 0);
        chk("rst_err", mem_err, 0);
        dmem_ack = 1'b1;
        dmem_rdata = 64'hCAFE;
        step();
        dmem_ack = 1'b0;
        chk("rst_late_ack_req", dmem_req, 0);
        chk("rst_late_ack_rdata", MW_ReadData, 0);
        chk("rst_late_ack_rw", MW_RegWrite, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage 64-bit RISC-V pipeline; consumes the EX/MEM pipeline register outputs (EXM_*).
- Drives the data-memory request/ack handshake and holds the pipeline via mem_stall while an access is outstanding.
- Resolves branches (PCSrc, branch_target) and registers MEM/WB outputs (MW_*) for writeback.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles in ACCESS without dmem_ack before abort; 1..255, counter is 8 bits.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- EXM_RegWrite, EXM_MemRead, EXM_MemToReg, EXM_MemWrite, EXM_Branch, EXM_Zero  in  1 each  control/flags from EX/MEM
- EXM_Adder_out  in  64  branch target
- EXM_ALUResult  in  64  ALU result / byte address
- EXM_ReadData2  in  64  store data
- EXM_rd  in  5  destination register
- dmem_rdata  in  64  read data, valid with dmem_ack
- dmem_ack  in  1  one-cycle completion strobe
- dmem_req  out  1  request, registered, held until ack or abort
- dmem_we  out  1  1=store, 0=load; registered
- dmem_addr  out  64  registered address
- dmem_wdata  out  64  registered store data
- mem_stall  out  1  combinational hold for PC/IF/ID/ID-EX/EX-MEM
- PCSrc  out  1  combinational EXM_Branch & EXM_Zero
- branch_target  out  64  combinational EXM_Adder_out
- MW_RegWrite, MW_MemToReg  out  1 each  to MEM/WB
- MW_ReadData, MW_ALUResult  out  64 each  to MEM/WB
- MW_rd  out  5  to MEM/WB
- mem_err  out  1  sticky timeout flag

Behaviour:
- Reset: all registered outputs 0 (dmem_req, dmem_we, dmem_addr, dmem_wdata, all MW_*, mem_err, timeout counter). FSM goes to IDLE. Reset mid-ACCESS drops dmem_req on the next edge and discards the access.
- Memory op present: mem_op = EXM_MemRead | EXM_MemWrite. If both are set, treat as a load (dmem_we=0).
- FSM states: IDLE and ACCESS.
- IDLE, mem_op=0:
  - MW_* <= EXM_* on the next edge; 1-cycle latency, MW_ReadData <= 0.
  - mem_stall=0.
- IDLE, mem_op=1:
  - mem_stall=1 (combinational).
  - On the edge: dmem_req<=1, dmem_we<=EXM_MemWrite & ~EXM_MemRead, dmem_addr<=EXM_ALUResult, dmem_wdata<=EXM_ReadData2, counter<=0.
  - Latch EXM_RegWrite, EXM_MemToReg, EXM_rd and EXM_ALUResult into internal holding registers.
  - MW_RegWrite<=0 (bubble), then go to ACCESS.
- ACCESS, dmem_ack=0:
  - mem_stall=1, MW_RegWrite<=0, counter increments.
  - When counter reaches TIMEOUT_CYCLES-1: dmem_req<=0, mem_err<=1, retire as bubble (MW_RegWrite<=0), go to IDLE.
- ACCESS, dmem_ack=1:
  - mem_stall=0 in the same cycle, so upstream advances on this edge.
  - dmem_req<=0.
  - MW_ReadData<=dmem_rdata; MW_RegWrite, MW_MemToReg, MW_rd and MW_ALUResult come from the holding registers.
  - Go to IDLE. The next instruction is evaluated in IDLE on the following cycle; back-to-back memory ops cost at least 2 cycles each.
- dmem_ack outside ACCESS is ignored.
- mem_err stays set until reset.
- PCSrc and branch_target depend on EXM_* only, independent of FSM state. Branches are never memory ops.
- A store with EXM_RegWrite=1 is still retired as specified; the decoder guarantees RegWrite=0 for stores.

Optional Feature:
- MEM_ALIGN_CHECK_EN defined:
  - In IDLE with mem_op=1 and EXM_ALUResult[2:0]!=0: no request is issued, mem_stall=0.
  - mem_misalign output pulses 1 for one cycle (registered). The op retires as a bubble (MW_RegWrite<=0) and the FSM stays in IDLE.
- Undefined: no mem_misalign port; the address is passed unmodified and the memory ignores low bits.

Test Plan:
- ALU op, no mem: EXM_RegWrite=1, ALUResult=0x2A, rd=5 -> next edge MW_RegWrite=1, MW_ALUResult=0x2A, MW_rd=5; mem_stall=0 throughout.
- Load, ack after 3 cycles: MemRead=1, MemToReg=1, ALUResult=0x100, rd=7, dmem_rdata=0xDEADBEEF -> dmem_req=1 with addr 0x100 and we=0; mem_stall high 4 cycles; at ack edge MW_ReadData=0xDEADBEEF, MW_RegWrite=1, MW_rd=7.
- Store, ack after 1 cycle: MemWrite=1, ALUResult=0x200, ReadData2=0x55 -> dmem_we=1, addr 0x200, wdata 0x55; MW_RegWrite stays 0; stall drops in the ack cycle.
- Timeout: TIMEOUT_CYCLES=4, load with ack never asserted -> dmem_req drops after 4 ACCESS cycles, mem_err=1 and stays 1, MW_RegWrite=0, FSM returns to IDLE.
- Reset mid-ACCESS: reset asserted 2 cycles into a load -> next edge dmem_req=0, all MW_*=0, mem_stall=0; a later dmem_ack is ignored.
- Branch: Branch=1, Zero=1, Adder_out=0x400 -> PCSrc=1, branch_target=0x400 in the same cycle; with Zero=0 -> PCSrc=0.
